// File: rtl/fb_bram_write_sched.sv
// Write-port scheduler for the framebuffer BRAM banks: round-robin between the
// serial loader (A) and the clear/pattern engine (B), then SETUP/STROBE/HOLD.
module fb_bram_write_sched #(
  parameter int NBANK         = 8,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [12:0]      a_addr,
  input  logic [7:0]       a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [12:0]      b_addr,
  input  logic [7:0]       b_data,
  output logic [7:0]       wr_addr,
  output logic [1:0]       wr_addr_hi,
  output logic [7:0]       wr_data,
  output logic [NBANK-1:0] wr_strobe,
  output logic             busy,
  output logic             done,
  output logic             last_grant
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST   = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [2:0]  bank;
  logic        idle;
  logic        grant_b;
  logic        accept;
  logic [12:0] sel_addr;
  logic [7:0]  sel_data;

  function automatic logic [NBANK-1:0] bank_onehot(input logic [2:0] idx);
    logic [NBANK-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // B wins when it is the only requester, or on a tie when A was served last.
  always_comb begin
    idle     = (state == IDLE);
    grant_b  = b_valid && (!a_valid || !last_grant);
    a_ready  = idle && a_valid && !grant_b;
    b_ready  = idle && grant_b;
    accept   = a_ready || b_ready;
    sel_addr = grant_b ? b_addr : a_addr;
    sel_data = grant_b ? b_data : a_data;
  end

  assign busy = !idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      bank       <= 3'd0;
      wr_addr    <= 8'd0;
      wr_addr_hi <= 2'd0;
      wr_data    <= 8'd0;
      wr_strobe  <= '0;
      done       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            wr_addr    <= sel_addr[7:0];
            wr_addr_hi <= sel_addr[9:8];
            wr_data    <= sel_data;
            bank       <= sel_addr[12:10];
            last_grant <= grant_b;
            state      <= SETUP;
          end
        end
        SETUP: begin
          wr_strobe <= bank_onehot(bank);
          cnt       <= 4'd0;
          state     <= STROBE;
        end
        STROBE: begin
          if (cnt == STROBE_LAST) begin
            wr_strobe <= '0;
            cnt       <= 4'd0;
            if (HOLD_CYCLES == 0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fb_bram_write_sched.md
Name: fb_bram_write_sched

Overview:
- Shares the 8 framebuffer BRAM banks' write port between two byte-write requesters.
- Requester A is the serial loader; requester B is the clear/pattern engine.
- Arbitrates round-robin, then runs a fixed SETUP -> STROBE -> HOLD sequence on the selected bank.
- Sits between the requesters and the bramN_wr_addr / wr_data / wr_data[20] (strobe) / wr_data[17:16] (high address) wiring. Read/scan-out ports are untouched.

Parameters:
- NBANK, 8: number of BRAM banks; strobe vector width; bank index = addr[12:10].
- STROBE_CYCLES, 2: cycles the bank strobe is held high; legal range 1..15.
- HOLD_CYCLES, 2: cycles address/data are held after the strobe falls; legal range 0..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- a_valid  in  1  requester A has a write pending
- a_ready  out  1  A's write accepted this cycle when a_valid is also high
- a_addr  in  13  A byte address: [12:10] bank, [9:8] high address, [7:0] word address
- a_data  in  8  A write byte
- b_valid  in  1  requester B has a write pending
- b_ready  out  1  B's write accepted this cycle when b_valid is also high
- b_addr  in  13  B byte address, same layout as a_addr
- b_data  in  8  B write byte
- wr_addr  out  8  registered word address, fanned out to all banks
- wr_addr_hi  out  2  registered high address bits, fanned out to all banks
- wr_data  out  8  registered write byte, fanned out to all banks
- wr_strobe  out  NBANK  one-hot bank write strobe
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle pulse when a write sequence completes
- last_grant  out  1  0 = A was served last, 1 = B was served last

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - wr_addr, wr_addr_hi, wr_data, wr_strobe, done, busy all 0.
  - last_grant = 1, so A wins the first tie.
- Reset asserted mid-sequence: wr_strobe drops to 0 immediately, no done pulse, the pending write is lost.
- FSM states are IDLE, SETUP, STROBE, HOLD.
- IDLE arbitration:
  - Only A valid: A wins. Only B valid: B wins.
  - Both valid: the requester that is not last_grant wins.
- IDLE handshake:
  - winner_ready = 1 and loser_ready = 0.
  - a_ready and b_ready are combinational from valid and state; both are 0 outside IDLE.
  - ready never asserts without the matching valid.
- Accept cycle T (valid && ready in IDLE):
  - Latch the winner's addr and data.
  - Update last_grant.
  - Next state = SETUP.
- Cycle T+1, SETUP:
  - wr_addr = addr[7:0], wr_addr_hi = addr[9:8], wr_data = data.
  - wr_strobe = 0.
- Cycles T+2 .. T+1+STROBE_CYCLES, STROBE:
  - wr_strobe has exactly bit addr[12:10] set.
  - A 4-bit counter times this state.
- Next HOLD_CYCLES cycles, HOLD:
  - wr_strobe = 0; addresses and data unchanged.
  - If HOLD_CYCLES = 0, STROBE goes directly to IDLE.
- Return to IDLE:
  - done = 1 during the first IDLE cycle after the sequence.
  - A new accept may occur in that same cycle.
  - Minimum accept-to-accept spacing is 2 + STROBE_CYCLES + HOLD_CYCLES cycles (6 at defaults).
- wr_addr, wr_addr_hi and wr_data keep their last values after a sequence; they are not cleared.
- Requests arriving while busy are held off (ready = 0); requesters must keep valid, addr and data stable until accepted.
- A deasserting valid before accept: no effect on the FSM.
- Address 13'h1FFF → bank 7, wr_addr_hi = 3, wr_addr = 8'hFF; no wrap or overflow handling is needed.
- busy = (state != IDLE).

Test Plan:
- Reset, then A-only write a_addr=13'h0C05, a_data=8'hA5 → a_ready high at T; T+1: wr_addr=05, wr_addr_hi=0, wr_data=A5, wr_strobe=0; T+2..T+3: wr_strobe=8'b0000_1000; T+4..T+5: strobe 0; done at T+6; last_grant=0.
- A and B valid together from reset (b_addr=13'h1FFF, b_data=8'h3C) → A served first, B accepted at T+6 → wr_strobe=8'h80, wr_addr=FF, wr_addr_hi=3; then A is served next while both stay valid (alternation).
- B held valid continuously with A absent → B accepted every 6 cycles; a_ready stays 0 throughout.
- Reset pulsed during the STROBE state → wr_strobe=0 in the same cycle, no done pulse, state IDLE, last_grant=1.
- STROBE_CYCLES=1, HOLD_CYCLES=0 → strobe high for 1 cycle at T+2; done and a back-to-back accept both at T+3.
- Valid driven while busy → ready remains 0 until the done cycle; outputs stay stable during HOLD.
